axi_grid_mni: RTL

//  Master network interface: grid-side endpoint that receives AXI request flits (AW/W/AR) from the grid,

---
 rtl/axi_grid_mni.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/axi_grid_mni.sv
// Master network interface: accepts AXI request flits from the grid, replays them as an AXI master
// toward the local slave, and routes B/R responses back to the requesting node via per-id tracking.
module axi_grid_mni #(
  parameter int NI_ID     = 0,
  parameter int GRID_ID_W = 4,
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MAX_OUT   = 7
) (
  input  logic                                    clk_i,
  input  logic                                    arst_ni,
  // grid request side
  input  logic                                    g_aw_valid_i,
  output logic                                    g_aw_ready_o,
  input  logic [GRID_ID_W+ID_W+ADDR_W+8-1:0]      g_aw_i,
  input  logic                                    g_w_valid_i,
  output logic                                    g_w_ready_o,
  input  logic [DATA_W+DATA_W/8+1-1:0]            g_w_i,
  input  logic                                    g_ar_valid_i,
  output logic                                    g_ar_ready_o,
  input  logic [GRID_ID_W+ID_W+ADDR_W+8-1:0]      g_ar_i,
  // grid response side
  output logic                                    g_b_valid_o,
  input  logic                                    g_b_ready_i,
  output logic [2*GRID_ID_W+ID_W+2-1:0]           g_b_o,
  output logic                                    g_r_valid_o,
  input  logic                                    g_r_ready_i,
  output logic [2*GRID_ID_W+ID_W+DATA_W+3-1:0]    g_r_o,
  // AXI master side
  output logic                                    m_aw_valid_o,
  input  logic                                    m_aw_ready_i,
  output logic [ID_W+ADDR_W+8-1:0]                m_aw_o,
  output logic                                    m_w_valid_o,
  input  logic                                    m_w_ready_i,
  output logic [DATA_W+DATA_W/8+1-1:0]            m_w_o,
  output logic                                    m_ar_valid_o,
  input  logic                                    m_ar_ready_i,
  output logic [ID_W+ADDR_W+8-1:0]                m_ar_o,
  input  logic                                    m_b_valid_i,
  output logic                                    m_b_ready_o,
  input  logic [ID_W+2-1:0]                       m_b_i,
  input  logic                                    m_r_valid_i,
  output logic                                    m_r_ready_o,
  input  logic [ID_W+DATA_W+3-1:0]                m_r_i,
  output logic                                    err_o
);

  // Handshake rule on every channel: a beat transfers on a rising edge where valid and ready are
  // both high; a raised valid stays high with stable payload until that transfer happens.

  localparam int GREQ_W   = GRID_ID_W + ID_W + ADDR_W + 8;
  localparam int MREQ_W   = ID_W + ADDR_W + 8;
  localparam int DEPTH    = 1 << ID_W;
  localparam int CNT_W    = $clog2(MAX_OUT + 1);
  localparam int CRED_MAX = DEPTH * MAX_OUT;
  localparam int CRED_W   = $clog2(CRED_MAX + 1);
  localparam logic [CNT_W-1:0]     CNT_FULL  = CNT_W'(MAX_OUT);
  localparam logic [CRED_W-1:0]    CRED_FULL = CRED_W'(CRED_MAX);
  localparam logic [GRID_ID_W-1:0] SELF      = GRID_ID_W'(NI_ID);

  logic [GRID_ID_W-1:0] wsrc [DEPTH];
  logic [CNT_W-1:0]     wcnt [DEPTH];
  logic [GRID_ID_W-1:0] rsrc [DEPTH];
  logic [CNT_W-1:0]     rcnt [DEPTH];

  logic                 aw_vld, ar_vld;
  logic [MREQ_W-1:0]    aw_q, ar_q;
  logic [CRED_W-1:0]    w_credit;

  logic [GRID_ID_W-1:0] aw_src, ar_src;
  logic [ID_W-1:0]      aw_id, ar_id, b_id, r_id;
  logic                 aw_acc, ar_acc, credit_ok, credit_nz;
  logic                 aw_hs_m, w_last_hs;
  logic                 b_known, r_known, b_hs, r_hs, w_ret, r_ret, r_last;
  logic [GRID_ID_W-1:0] b_dst, r_dst;

  assign aw_src = g_aw_i[GREQ_W-1 -: GRID_ID_W];
  assign aw_id  = g_aw_i[ADDR_W+8 +: ID_W];
  assign ar_src = g_ar_i[GREQ_W-1 -: GRID_ID_W];
  assign ar_id  = g_ar_i[ADDR_W+8 +: ID_W];
  assign b_id   = m_b_i[2 +: ID_W];
  assign r_id   = m_r_i[DATA_W+3 +: ID_W];
  assign r_last = m_r_i[0];

  // The AW register is counted against the credit so the counter can never pass its ceiling.
  assign credit_ok = (w_credit + CRED_W'(aw_vld)) < CRED_FULL;
  assign credit_nz = w_credit != '0;

  assign g_aw_ready_o = arst_ni & (!aw_vld | m_aw_ready_i)
                      & ((wcnt[aw_id] == '0) | (wsrc[aw_id] == aw_src))
                      & (wcnt[aw_id] < CNT_FULL) & credit_ok;
  assign g_ar_ready_o = arst_ni & (!ar_vld | m_ar_ready_i)
                      & ((rcnt[ar_id] == '0) | (rsrc[ar_id] == ar_src))
                      & (rcnt[ar_id] < CNT_FULL);
  assign aw_acc = g_aw_valid_i & g_aw_ready_o;
  assign ar_acc = g_ar_valid_i & g_ar_ready_o;

  assign m_aw_valid_o = aw_vld;
  assign m_aw_o       = aw_q;
  assign m_ar_valid_o = ar_vld;
  assign m_ar_o       = ar_q;

  // Write data is only released once its AW has left on the master side.
  assign g_w_ready_o = arst_ni & m_w_ready_i & credit_nz;
  assign m_w_valid_o = arst_ni & g_w_valid_i & credit_nz;
  assign m_w_o       = g_w_i;
  assign aw_hs_m     = m_aw_valid_o & m_aw_ready_i;
  assign w_last_hs   = g_w_valid_i & g_w_ready_o & g_w_i[0];

  assign b_known     = wcnt[b_id] != '0;
  assign b_dst       = b_known ? wsrc[b_id] : SELF;
  assign g_b_valid_o = arst_ni & m_b_valid_i;
  assign m_b_ready_o = arst_ni & g_b_ready_i;
  assign g_b_o       = {b_dst, SELF, m_b_i};
  assign b_hs        = g_b_valid_o & g_b_ready_i;
  assign w_ret       = b_hs & b_known;

  assign r_known     = rcnt[r_id] != '0;
  assign r_dst       = r_known ? rsrc[r_id] : SELF;
  assign g_r_valid_o = arst_ni & m_r_valid_i;
  assign m_r_ready_o = arst_ni & g_r_ready_i;
  assign g_r_o       = {r_dst, SELF, m_r_i};
  assign r_hs        = g_r_valid_o & g_r_ready_i;
  assign r_ret       = r_hs & r_last & r_known;

  assign err_o = (b_hs & !b_known) | (r_hs & !r_known);

  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      aw_vld <= 1'b0;
      ar_vld <= 1'b0;
    end else begin
      if (aw_acc)            aw_vld <= 1'b1;
      else if (m_aw_ready_i) aw_vld <= 1'b0;
      if (ar_acc)            ar_vld <= 1'b1;
      else if (m_ar_ready_i) ar_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_acc) aw_q <= g_aw_i[MREQ_W-1:0];
    if (ar_acc) ar_q <= g_ar_i[MREQ_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!arst_ni)                    w_credit <= '0;
    else if (aw_hs_m && !w_last_hs)  w_credit <= w_credit + CRED_W'(1);
    else if (!aw_hs_m && w_last_hs)  w_credit <= w_credit - CRED_W'(1);
  end

  // An accept and a retire on the same id cancel; the new requester still takes ownership.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!arst_ni) begin
        wcnt[i] <= '0;
        wsrc[i] <= '0;
        rcnt[i] <= '0;
        rsrc[i] <= '0;
      end else begin
        if (aw_acc && aw_id == ID_W'(i)) begin
          wsrc[i] <= aw_src;
          if (!(w_ret && b_id == ID_W'(i))) wcnt[i] <= wcnt[i] + CNT_W'(1);
        end else if (w_ret && b_id == ID_W'(i)) begin
          wcnt[i] <= wcnt[i] - CNT_W'(1);
        end
        if (ar_acc && ar_id == ID_W'(i)) begin
          rsrc[i] <= ar_src;
          if (!(r_ret && r_id == ID_W'(i))) rcnt[i] <= rcnt[i] + CNT_W'(1);
        end else if (r_ret && r_id == ID_W'(i)) begin
          rcnt[i] <= rcnt[i] - CNT_W'(1);
        end
      end
    end
  end

endmodule
